// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/control/result bundle for the serial adder-subtractor
// The master drives the operation request; the slave returns status and the registered result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_ns;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, abort, a, b, a_ns,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, abort, a, b, a_ns,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle adder/subtractor processing BITS_PER_CYCLE bits per clock
// Operands are captured into shift registers and consumed LSB slice first through a carry register.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH-1:0]    acc;
  logic                carry;
  logic [CW-1:0]       slice;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    result_q;
  logic                cout_q;
  logic                ovf_q;
  logic                zero_q;

  logic [BITS_PER_CYCLE-1:0]       sum;
  logic [BITS_PER_CYCLE:0]         c;
  logic [WIDTH+BITS_PER_CYCLE-1:0] acc_wide;
  logic [WIDTH-1:0]                acc_next;

  // Ripple the current slice; the finished slice enters acc from the top so
  // after NSLICE shifts the LSB slice has landed at bit 0.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sum[i]   = op_a[i] ^ op_b[i] ^ c[i];
      c[i+1]   = (op_a[i] & op_b[i]) | (op_a[i] & c[i]) | (op_b[i] & c[i]);
    end
    acc_wide = {sum, acc};
    acc_next = acc_wide[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      slice    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.a_ns ? bus.b : ~bus.b;
            acc    <= '0;
            carry  <= ~bus.a_ns;
            slice  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            op_a  <= op_a >> BITS_PER_CYCLE;
            op_b  <= op_b >> BITS_PER_CYCLE;
            acc   <= acc_next;
            carry <= c[BITS_PER_CYCLE];
            slice <= slice + CW'(1);
            if (slice == LAST) begin
              // Last slice holds the MSB, so its top two carries give signed overflow.
              result_q <= acc_next;
              cout_q   <= c[BITS_PER_CYCLE];
              ovf_q    <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
              zero_q   <= (acc_next == '0);
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub (8x1 and 16x4 builds)
// Expected results are hand-computed constants; timing is sampled on the falling edge.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       add;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] res_of(input bit w16);
    return w16 ? 64'(if16.result) : 64'(if8.result);
  endfunction

  // {busy, done, cout, ovf, zero}
  function automatic logic [4:0] flags_of(input bit w16);
    if (w16) return {if16.busy, if16.done, if16.cout, if16.ovf, if16.zero};
    return {if8.busy, if8.done, if8.cout, if8.ovf, if8.zero};
  endfunction

  task automatic drive(input bit w16, input bit st, input logic [63:0] av, input logic [63:0] bv,
                       input bit add);
    if (w16) begin
      if16.start = st; if16.a = av[15:0]; if16.b = bv[15:0]; if16.a_ns = add;
    end else begin
      if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0]; if8.a_ns = add;
    end
  endtask

  task automatic drive_ctl(input bit w16, input bit st, input bit ab);
    if (w16) begin
      if16.start = st; if16.abort = ab;
    end else begin
      if8.start = st; if8.abort = ab;
    end
  endtask

  // Called at the negedge where start was just driven; done must appear nrun+1 negedges later.
  task automatic finish_op(input string tag, input bit w16, input logic [63:0] er, input logic ec,
                           input logic ev, input logic ez, input int nrun);
    int lat;
    logic [4:0] f;
    @(negedge clk);
    drive_ctl(w16, 1'b0, 1'b0);
    f = flags_of(w16);
    check({tag, " busy"}, f[4], 1'b1);
    lat = 1;
    while (f[3] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      f = flags_of(w16);
    end
    check({tag, " latency"}, lat, nrun + 1);
    check({tag, " result"}, res_of(w16), er);
    check({tag, " cout/ovf/zero"}, f[2:0], {ec, ev, ez});
    check({tag, " busy at done"}, f[4], 1'b0);
    @(negedge clk);
    f = flags_of(w16);
    check({tag, " done one cycle"}, f[3], 1'b0);
  endtask

  task automatic do_op(input string tag, input bit w16, input logic [63:0] av, input logic [63:0] bv,
                       input bit add, input logic [63:0] er, input logic ec, input logic ev,
                       input logic ez, input int nrun);
    @(negedge clk);
    drive(w16, 1'b1, av, bv, add);
    finish_op(tag, w16, er, ec, ev, ez, nrun);
  endtask

  initial begin
    int dcount;
    int t[3];
    int n;
    logic [4:0] f;

    vecs[0] = '{8'd100, 8'd27,  1'b1, 8'd127, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd100, 8'd28,  1'b1, 8'h80,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF,  8'h01,  1'b1, 8'h00,  1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'd5,   8'd7,   1'b0, 8'hFE,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'd7,   8'd7,   1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b1, 1'b1, 1'b0};

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b1);
    drive_ctl(1'b0, 1'b0, 1'b0);
    drive_ctl(1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #11;
    check("reset result8", res_of(1'b0), 64'd0);
    check("reset flags8", flags_of(1'b0), 5'b0);
    check("reset flags16", flags_of(1'b1), 5'b0);

    // Release reset and request in the same cycle: first edge must take it.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 64'(vecs[0].a), 64'(vecs[0].b), vecs[0].add);
    finish_op("add 100+27", 1'b0, 64'(vecs[0].r), vecs[0].c, vecs[0].v, vecs[0].z, 8);

    for (int i = 1; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), 1'b0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].add,
            64'(vecs[i].r), vecs[i].c, vecs[i].v, vecs[i].z, 8);
    end

    // start and operand changes during RUN must not disturb the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h10, 64'h20, 1'b1);
    @(negedge clk);
    drive_ctl(1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 2; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) drive(1'b0, 1'b1, 64'hFF, 64'hFF, 1'b0);
      if (i == 6) drive_ctl(1'b0, 1'b0, 1'b0);
      f = flags_of(1'b0);
      if (f[3] === 1'b1) dcount++;
    end
    check("mid-run start done count", dcount, 1);
    check("mid-run start result", res_of(1'b0), 64'h30);
    check("mid-run start idle", flags_of(1'b0) & 5'b11000, 5'b0);

    // abort at RUN cycle 4, with start also high: abort wins
    do_op("add 11+22", 1'b0, 64'h11, 64'h22, 1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 8);
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h01, 64'h01, 1'b1);
    @(negedge clk);
    drive_ctl(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive_ctl(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive_ctl(1'b0, 1'b0, 1'b0);
    f = flags_of(1'b0);
    check("abort busy/done", f[4:3], 2'b00);
    check("abort result held", res_of(1'b0), 64'h33);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f = flags_of(1'b0);
      if (f[3] === 1'b1 || f[4] === 1'b1) dcount++;
    end
    check("abort stays idle", dcount, 0);
    check("abort result still held", res_of(1'b0), 64'h33);

    // abort in IDLE has no effect on a simultaneous start
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h40, 64'h02, 1'b0);
    drive_ctl(1'b0, 1'b1, 1'b1);
    finish_op("idle abort sub 40-02", 1'b0, 64'h3E, 1'b1, 1'b0, 1'b0, 8);

    // asynchronous reset in RUN cycle 3
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h80, 64'h01, 1'b0);
    @(negedge clk);
    drive_ctl(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset result", res_of(1'b0), 64'd0);
    check("async reset flags", flags_of(1'b0), 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      f = flags_of(1'b0);
      if (f[4] === 1'b1 || f[3] === 1'b1) dcount++;
    end
    check("post reset idle", dcount, 0);
    do_op("after reset sub 5-7", 1'b0, 64'd5, 64'd7, 1'b0, 64'hFE, 1'b0, 1'b0, 1'b0, 8);

    // 16-bit build, 4 bits per cycle
    do_op("w16 7FFF+1", 1'b1, 64'h7FFF, 64'h0001, 1'b1, 64'h8000, 1'b0, 1'b1, 1'b0, 4);

    @(negedge clk);
    drive(1'b1, 1'b1, 64'h1234, 64'h0101, 1'b1);
    n = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      f = flags_of(1'b1);
      if (f[3] === 1'b1) begin
        if (n < 3) t[n] = i;
        n++;
      end
    end
    drive_ctl(1'b1, 1'b0, 1'b0);
    check("b2b done count", n, 3);
    if (n >= 3) begin
      check("b2b first latency", t[0], 5);
      check("b2b period 1", t[1] - t[0], 5);
      check("b2b period 2", t[2] - t[1], 5);
    end
    check("b2b result", res_of(1'b1), 64'h1335);
    repeat (8) @(negedge clk);
    check("b2b stops", flags_of(1'b1) & 5'b11000, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
